// File: rtl/ex_muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit that owns the HI/LO registers.
// Shift-add multiply and restoring divide both run in one shared 2*WIDTH accumulator.
module ex_muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             md_start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             hilo_read,
    input  logic             flush,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;
    typedef enum logic [2:0] {
        OP_NOP, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_RSVD
    } op_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH-1:0]   rs_q;
    logic               is_div_q;
    logic               neg_lo_q;
    logic               neg_hi_q;
    logic               divz_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;

    op_t              op;
    logic             signed_op;
    logic [WIDTH-1:0] abs_rs;
    logic [WIDTH-1:0] abs_rt;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next_d;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] div_next_d;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fix_hi_d;
    logic [WIDTH-1:0]   fix_lo_d;

    always_comb begin
        op        = op_t'(md_op);
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        abs_rs    = (signed_op && rs_val[WIDTH-1]) ? -rs_val : rs_val;
        abs_rt    = (signed_op && rt_val[WIDTH-1]) ? -rt_val : rt_val;
    end

    // Multiply: low half holds the remaining multiplier bits, product grows from the top.
    always_comb begin
        mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next_d = {mul_sum, acc_q[WIDTH-1:1]};
    end

    // Divide: high half is the partial remainder, low half shifts dividend out / quotient in.
    always_comb begin
        div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff = div_sh[WIDTH-1:0] - opnd_q;
        if (div_sh >= {1'b0, opnd_q}) begin
            div_next_d = {div_diff, acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_next_d = {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        prod = neg_lo_q ? -acc_q : acc_q;
        if (!is_div_q) begin
            fix_hi_d = prod[2*WIDTH-1:WIDTH];
            fix_lo_d = prod[WIDTH-1:0];
        end else if (divz_q) begin
            fix_hi_d = rs_q;
            fix_lo_d = '1;
        end else begin
            fix_hi_d = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
            fix_lo_d = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            rs_q     <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            divz_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (md_start && !flush) begin
                        case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                is_div_q <= (op == OP_DIV) || (op == OP_DIVU);
                                acc_q    <= (op == OP_DIV || op == OP_DIVU) ?
                                            {{WIDTH{1'b0}}, abs_rs} : {{WIDTH{1'b0}}, abs_rt};
                                opnd_q   <= (op == OP_DIV || op == OP_DIVU) ? abs_rt : abs_rs;
                                neg_lo_q <= signed_op && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                                neg_hi_q <= (op == OP_DIV) && rs_val[WIDTH-1];
                                divz_q   <= (rt_val == '0);
                                rs_q     <= rs_val;
                                cnt_q    <= CW'(WIDTH);
                                busy_q   <= 1'b1;
                                state_q  <= S_CALC;
                            end
                            OP_MTHI: hi_q <= rs_val;
                            OP_MTLO: lo_q <= rs_val;
                            default: ;
                        endcase
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        acc_q <= is_div_q ? div_next_d : mul_next_d;
                        cnt_q <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
                            state_q <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (!flush) begin
                        hi_q   <= fix_hi_d;
                        lo_q   <= fix_lo_d;
                        done_q <= 1'b1;
                    end
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign hi    = hi_q;
    assign lo    = lo_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign stall = busy_q & (md_start | hilo_read);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: arithmetic reference model checked every cycle plus directed literals.
module tb_ex_muldiv_unit;

    localparam int unsigned W = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         md_start = 1'b0;
    logic [2:0]   md_op = 3'd0;
    logic [W-1:0] rs_val = '0;
    logic [W-1:0] rt_val = '0;
    logic         hilo_read = 1'b0;
    logic         flush = 1'b0;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;
    logic         stall;

    ex_muldiv_unit #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .md_start(md_start), .md_op(md_op),
        .rs_val(rs_val), .rt_val(rt_val), .hilo_read(hilo_read), .flush(flush),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: a pending result plus the number of cycles left before it lands.
    int         m_rem  = 0;
    logic       m_done = 1'b0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic [W-1:0] p_hi = '0;
    logic [W-1:0] p_lo = '0;

    function automatic logic [63:0] expect_hilo(input logic [2:0] op, input logic [31:0] a,
                                                input logic [31:0] b);
        longint sa, sb, q, r;
        longint unsigned ua, ub, up;
        logic [31:0] uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd1: begin q = sa * sb; return q; end
            3'd2: begin up = ua * ub; return up; end
            3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'd4: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                uq = a / b;
                ur = a % b;
                return {ur, uq};
            end
            default: return 64'd0;
        endcase
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_rem <= 0; m_done <= 1'b0; m_hi <= '0; m_lo <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_rem != 0) begin
                if (flush) begin
                    m_rem <= 0;
                end else begin
                    m_rem <= m_rem - 1;
                    if (m_rem == 1) begin
                        m_hi <= p_hi; m_lo <= p_lo; m_done <= 1'b1;
                    end
                end
            end else if (md_start && !flush) begin
                if (md_op >= 3'd1 && md_op <= 3'd4) begin
                    {p_hi, p_lo} <= expect_hilo(md_op, rs_val, rt_val);
                    m_rem <= W + 1;
                end else if (md_op == 3'd5) begin
                    m_hi <= rs_val;
                end else if (md_op == 3'd6) begin
                    m_lo <= rs_val;
                end
            end
        end
    end

    logic         s_busy, s_done, s_stall;
    logic [W-1:0] s_hi, s_lo;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Sample and compare at the falling edge, then advance past the next rising edge.
    task automatic tick();
        @(negedge clock);
        s_busy = busy; s_done = done; s_stall = stall; s_hi = hi; s_lo = lo;
        chk("busy",  s_busy,  m_rem != 0);
        chk("done",  s_done,  m_done);
        chk("hi",    s_hi,    m_hi);
        chk("lo",    s_lo,    m_lo);
        chk("stall", s_stall, (m_rem != 0) && (md_start || hilo_read));
        @(posedge clock);
        #1;
    endtask

    task automatic start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        md_start = 1'b1; md_op = op; rs_val = a; rt_val = b;
        tick();
        md_start = 1'b0; md_op = 3'd0;
    endtask

    task automatic wait_done(output int nbusy);
        nbusy = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (s_busy) nbusy++;
            if (s_done) break;
        end
        chk("done_seen", s_done, 1'b1);
    endtask

    int n;

    initial begin
        repeat (2) @(posedge clock);
        #1;
        tick();
        chk("reset_busy", s_busy, 1'b0);
        chk("reset_hi", s_hi, 32'd0);
        reset = 1'b0;
        tick();

        start(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(n);
        chk("multu_latency", n, 33);
        chk("multu_hi", s_hi, 32'hFFFF_FFFE);
        chk("multu_lo", s_lo, 32'h0000_0001);
        tick();

        start(3'd1, 32'hFFFF_FFFD, 32'd7);
        wait_done(n);
        chk("mult_hi", s_hi, 32'hFFFF_FFFF);
        chk("mult_lo", s_lo, 32'hFFFF_FFEB);
        start(3'd3, 32'hFFFF_FFF9, 32'd2);
        wait_done(n);
        chk("div_lo", s_lo, 32'hFFFF_FFFD);
        chk("div_hi", s_hi, 32'hFFFF_FFFF);

        start(3'd4, 32'd100, 32'd0);
        wait_done(n);
        chk("divz_latency", n, 33);
        chk("divz_lo", s_lo, 32'hFFFF_FFFF);
        chk("divz_hi", s_hi, 32'd100);
        start(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n);
        chk("divovf_lo", s_lo, 32'h8000_0000);
        chk("divovf_hi", s_hi, 32'd0);

        start(3'd1, 32'hFFFF_FFFF, 32'd2);
        hilo_read = 1'b1; md_start = 1'b1; md_op = 3'd4; rs_val = 32'd9; rt_val = 32'd4;
        n = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (s_stall) n++;
            if (s_done) break;
        end
        chk("held_stall_cycles", n, 33);
        chk("held_mult_lo", s_lo, 32'hFFFF_FFFE);
        md_start = 1'b0; md_op = 3'd0; hilo_read = 1'b0;
        wait_done(n);
        chk("held_divu_latency", n, 33);
        chk("held_divu_lo", s_lo, 32'd2);
        chk("held_divu_hi", s_hi, 32'd1);

        md_start = 1'b1; md_op = 3'd5; rs_val = 32'h1234_5678;
        tick();
        md_op = 3'd6; rs_val = 32'h9ABC_DEF0;
        tick();
        md_start = 1'b0; md_op = 3'd0;
        tick();
        chk("mthi", s_hi, 32'h1234_5678);
        chk("mtlo", s_lo, 32'h9ABC_DEF0);

        flush = 1'b1; md_start = 1'b1; md_op = 3'd5; rs_val = 32'hDEAD_BEEF;
        tick();
        flush = 1'b0; md_start = 1'b0; md_op = 3'd0;
        tick();
        chk("idle_flush_hi", s_hi, 32'h1234_5678);

        start(3'd2, 32'h0000_FFFF, 32'h0000_FFFF);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        chk("flush_busy", s_busy, 1'b0);
        chk("flush_hi", s_hi, 32'h1234_5678);
        chk("flush_lo", s_lo, 32'h9ABC_DEF0);
        repeat (36) tick();

        start(3'd2, 32'd3, 32'd5);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; hilo_read = 1'b1;
        tick();
        chk("rst_hi", s_hi, 32'd0);
        chk("rst_lo", s_lo, 32'd0);
        chk("rst_busy", s_busy, 1'b0);
        chk("rst_stall", s_stall, 1'b0);
        hilo_read = 1'b0;

        start(3'd2, 32'd3, 32'd5);
        wait_done(n);
        chk("post_rst_lo", s_lo, 32'd15);
        chk("post_rst_hi", s_hi, 32'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- EX-stage consumer of the ID/EX pipeline register outputs for the HI/LO instruction class.
- Takes the latched rs and rt operand values (ID_EX_mux8_out, ID_EX_mux9_out) plus a decoded mult/div opcode, and runs iterative 32-bit multiply/divide.
- Owns the architectural HI/LO registers and raises stall toward the hazard/pipeline-enable logic while an operation is in flight.

Parameters:
- WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- md_start  input  1  valid request from EX this cycle.
- md_op  input  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP).
- rs_val  input  WIDTH  operand A / dividend / MTHI-MTLO source.
- rt_val  input  WIDTH  operand B / divisor.
- hilo_read  input  1  EX holds MFHI/MFLO this cycle.
- flush  input  1  abort in-flight op (exception/branch squash).
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- busy  output  1  iterative op in flight.
- done  output  1  one-cycle pulse when HI/LO are updated by MULT/DIV.
- stall  output  1  freeze IF/ID/EX; combinational = busy & (md_start | hilo_read).

Behaviour:
- Reset values (synchronous; reset wins over every other input): hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0, internal accumulators=0.
- Reset mid-operation: return to IDLE next edge; partial result discarded; hi/lo cleared.
- States: IDLE, CALC, FIX.
- IDLE, accept edge E0:
  - md_start with op 1-4 -> latch |rs|, |rt| (MULT/DIV signs via two's complement; MULTU/DIVU raw), record result signs, counter=WIDTH; go to CALC; busy=1 from E0.
  - md_start with op 5/6 -> write hi (MTHI) or lo (MTLO) at E0; stay IDLE; busy stays 0; done stays 0.
  - md_start with op 0/7 -> no effect.
- CALC: one iteration per edge, counter decrements; leave CALC when counter reaches 0, i.e. after edge E_WIDTH.
  - Multiply: shift-add; 2*WIDTH-bit product accumulator.
  - Divide: restoring; WIDTH-bit remainder, WIDTH-bit quotient.
- FIX, edge E_(WIDTH+1):
  - Apply sign correction, write hi/lo, set done=1 for that cycle, busy=0, return to IDLE.
  - MULT/MULTU: {hi,lo} = 64-bit product, negated if operand signs differ (MULT only).
  - DIV/DIVU: lo=quotient, hi=remainder; DIV quotient sign = sign(rs) xor sign(rt); remainder sign = sign(rs).
  - Divisor zero (DIV or DIVU): lo=all ones, hi=original rs_val; same latency; no exception.
  - Signed overflow case DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Total latency: accept to hi/lo valid = WIDTH+1 edges (33 at default); busy high for exactly WIDTH+1 cycles.
- md_start while busy: not accepted; stall=1 holds EX so the request is re-presented every cycle; it is accepted on the first IDLE cycle (the cycle after FIX).
- hilo_read while busy: stall=1; hi/lo are not valid until done.
- hilo_read in IDLE: no stall; hi/lo reflect the last completed write.
- flush:
  - In CALC or FIX: go to IDLE next edge, busy=0, done=0, hi/lo unchanged.
  - In IDLE with md_start the same cycle: request ignored, including MTHI/MTLO.
  - reset has priority over flush.
- done and the MTHI/MTLO write never coincide, since MTHI/MTLO is only accepted in IDLE.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 33 edges hi=0xFFFFFFFE, lo=0x00000001; done pulses once; busy high 33 cycles.
- MULT rs=0xFFFFFFFD (-3), rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; then DIV rs=-7 (0xFFFFFFF9), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU rs=100, rt=0 -> lo=0xFFFFFFFF, hi=100, latency 33; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MULT in flight, hilo_read=1 and a second md_start DIVU 9/4 held -> stall=1 until FIX; DIVU accepted the cycle after done; final lo=2, hi=1.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles -> hi/lo updated at each accept edge; busy=0 and done=0 throughout.
- MULTU started, flush asserted at iteration 10 -> IDLE next edge, hi/lo keep prior values; separately, reset at iteration 5 -> hi=lo=0, busy=0, stall=0.
